chunked_rca_adder: RTL
======================

Name: chunked_rca_adder

Overview:
Parametrised multi-cycle ripple-carry adder/subtractor. It processes a WIDTH-bit operation one CHUNK-bit ripple slice per clock, LSB slice first, and holds the inter-slice carry in a register. A valid/ready handshake on both input and output lets it sit between pipeline stages of the datapath. It trades latency for a short critical path: only one CHUNK-bit ripple chain lies between registers.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 8, slice width added per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK (localparam), WIDTH/CHUNK, number of compute cycles per operation.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands present
in_ready  out  1  block can accept operands; high only in IDLE
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry in; ignored when sub=1
sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1)
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB; in subtract mode 1 = no borrow
ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: rst_n low forces IDLE immediately, independent of clk.
- Reset values: sum=0, cout=0, ovf=0, out_valid=0, chunk counter=0, carry register=0, in_ready=1 (IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a_r=a, b_r=(sub ? ~b : b), carry_r=(sub ? 1 : cin), cnt=0, then go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0.
  - Each edge computes {c, s} = a_r[k] + b_r[k] + carry_r, where k = cnt selects bits [k*CHUNK +: CHUNK].
  - Write s into sum[k*CHUNK +: CHUNK] and set carry_r=c.
  - For the top slice only, capture the carry into bit WIDTH-1 for ovf.
  - cnt increments. On the edge where cnt=NCHUNK-1: set cout=c and ovf=(carry into MSB)^c, then go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE and set out_valid=0. sum, cout and ovf keep their last values.
- Latency: out_valid first seen high NCHUNK edges after the accepting edge. Throughput: one operation per NCHUNK+2 cycles at best.
- Input handshake: in_valid while busy (RUN or DONE) has no effect. Operands are sampled only on the accepting edge; later changes to a, b, cin or sub do not affect the result in flight.
- No input/output overlap: in_ready stays 0 during the DONE->IDLE transition edge.
- NCHUNK=1: a single RUN cycle, giving a purely registered full-width add.
- Wrap-around: the result is modulo 2^WIDTH, and the carry out is reported only via cout.
- rst_n low mid-operation: the operation is aborted, outputs go to reset values, and out_valid is never asserted for that operation.
- A WIDTH not divisible by CHUNK is illegal and must be rejected at elaboration (generate-time error).

Test Plan:
1. WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0; out_valid rises exactly 4 edges after accept; carry crosses all 4 slices.
2. Subtract: a=0x00000005, b=0x00000007, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
3. Signed overflow add: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles after out_valid: out_valid=1 and sum/cout/ovf unchanged every cycle, in_ready=0.
   - Pulse in_valid with new operands during this window: the result is unaffected and those operands are not accepted.
   - Release out_ready: out_valid drops after 1 edge and in_ready returns to 1.
5. Reset mid-op: accept a=0x12345678, b=0x11111111; drop rst_n asynchronously between edges after 2 RUN edges -> sum=0, cout=0, ovf=0, out_valid=0 and in_ready=1 immediately. After release, a new op 0x1+0x1 yields 0x00000002.
6. WIDTH=8, CHUNK=8: a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1, out_valid after 1 edge. Back-to-back ops with in_valid held high and out_ready held high -> one result every NCHUNK+2 cycles, no result dropped or duplicated.

Source files
------------

// File: rtl/chunked_rca_adder_if.sv
// Operand/result handshake bundle for chunked_rca_adder; master supplies operands
// and out_ready, slave (the adder) returns in_ready and the registered result.
interface chunked_rca_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_rca_adder.sv
// Multi-cycle add/sub, one CHUNK-bit ripple slice per clock; result valid WIDTH/CHUNK edges after accept.
// Accepts only in IDLE; the result is held in DONE until out_ready, with no input/output overlap.
module chunked_rca_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                clk,
  input logic                rst_n,
  chunked_rca_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("chunked_rca_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK-1:0]  a_k;
  logic [CHUNK-1:0]  b_k;
  logic [CHUNK:0]    slice;
  logic              msb_cin;
  logic              last;

  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        a_k = a_q[k*CHUNK +: CHUNK];
        b_k = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign slice   = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c_in.
  assign msb_cin = a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ slice[CHUNK-1];
  assign last    = (cnt_q == CW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
          end
        end
        carry_d = slice[CHUNK];
        if (last) begin
          cout_d  = slice[CHUNK];
          ovf_d   = msb_cin ^ slice[CHUNK];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
